// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier handshake bundle for the shared-multiplier arbiter.
// The arbiter connects through the slave modport; the surrounding environment
// (requesters plus the multiplier) uses the master modport.
interface mult_share_arbiter_if #(
  parameter int NBITS = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_iValid;
  logic [NREQ-1:0]       req_iReady;
  logic [NREQ*NBITS-1:0] req_A;
  logic [NREQ*NBITS-1:0] req_B;
  logic [NREQ-1:0]       req_oValid;
  logic [NREQ-1:0]       req_oReady;
  logic [2*NBITS-1:0]    req_result;
  logic [NBITS-1:0]      m_A;
  logic [NBITS-1:0]      m_B;
  logic                  m_iValid;
  logic                  m_iReady;
  logic                  m_oValid;
  logic                  m_oReady;
  logic [2*NBITS-1:0]    m_result;

  modport slave (
    input  req_iValid, req_A, req_B, req_oReady, m_iReady, m_oValid, m_result,
    output req_iReady, req_oValid, req_result, m_A, m_B, m_iValid, m_oReady
  );

  modport master (
    output req_iValid, req_A, req_B, req_oReady, m_iReady, m_oValid, m_result,
    input  req_iReady, req_oValid, req_result, m_A, m_B, m_iValid, m_oReady
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that shares one multiplier among NREQ requesters.
// One transaction at a time: accept operands, issue to the multiplier,
// collect the product, hand it back to the owner, then rotate priority.
module mult_share_arbiter #(
  parameter int NBITS = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clock,
  input  logic                reset,
  mult_share_arbiter_if.slave bus,
  output logic                busy,
  output logic [IDW-1:0]      owner,
  output logic [15:0]         done_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [NBITS-1:0]   lat_a;
  logic [NBITS-1:0]   lat_b;
  logic [2*NBITS-1:0] lat_res;
  logic               m_ivalid_q;
  logic               m_oready_q;
  logic [NREQ-1:0]    ovalid_q;
  logic               busy_q;

  logic [IDW-1:0]     grant;
  logic               found;
  logic [IDW:0]       sum;
  logic [IDW-1:0]     cand;
  logic [NREQ-1:0]    grant_oh;
  logic [NREQ-1:0]    owner_oh;
  logic [NBITS-1:0]   sel_a;
  logic [NBITS-1:0]   sel_b;

  // Search requesters starting at rr_ptr, wrapping modulo NREQ; first valid wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!found && bus.req_iValid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // One-hot forms of the grant and the owner, plus the granted operands
  always_comb begin
    grant_oh = '0;
    owner_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    grant_oh[grant] = found;
    owner_oh[owner] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a = bus.req_A[i*NBITS +: NBITS];
        sel_b = bus.req_B[i*NBITS +: NBITS];
      end
    end
  end

  // Accept is combinational so a waiting requester is taken on the first IDLE cycle;
  // it is also forced low while reset is asserted.
  assign bus.req_iReady = (state == IDLE && reset) ? grant_oh : '0;
  assign bus.req_oValid = ovalid_q;
  assign bus.req_result = lat_res;
  assign bus.m_A        = lat_a;
  assign bus.m_B        = lat_b;
  assign bus.m_iValid   = m_ivalid_q;
  assign bus.m_oReady   = m_oready_q;
  assign busy           = busy_q;

  // Transaction sequencer with registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_res    <= '0;
      m_ivalid_q <= 1'b0;
      m_oready_q <= 1'b0;
      ovalid_q   <= '0;
      busy_q     <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            lat_a      <= sel_a;
            lat_b      <= sel_b;
            owner      <= grant;
            m_ivalid_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_iReady) begin
            m_ivalid_q <= 1'b0;
            m_oready_q <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.m_oValid) begin
            lat_res    <= bus.m_result;
            m_oready_q <= 1'b0;
            ovalid_q   <= owner_oh;
            state      <= RETURN;
          end
        end
        RETURN: begin
          // Only the owner's ready matters; priority moves just past the owner
          if (bus.req_oReady[owner]) begin
            ovalid_q   <= '0;
            busy_q     <= 1'b0;
            owner      <= '0;
            rr_ptr     <= (owner == IDW'(NREQ-1)) ? '0 : owner + IDW'(1);
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: drives four requesters and models a small
// sequential multiplier (fixed latency, optional input stall).
module tb_mult_share_arbiter;

  logic        clock;
  logic        reset;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] done_count;

  mult_share_arbiter_if #(.NBITS(8), .NREQ(4)) bus();

  mult_share_arbiter #(.NBITS(8), .NREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .owner      (owner),
    .done_count (done_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier model: accepts when idle, result valid two cycles later, held until taken
  logic        mbusy;
  logic        mvalid;
  logic        mstall;
  logic [2:0]  mcnt;
  logic [15:0] mprod;

  assign bus.m_iReady = !mbusy && !mvalid && !mstall;
  assign bus.m_oValid = mvalid;
  assign bus.m_result = mprod;

  // Multiplier model state, sharing the arbiter reset
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mbusy  <= 1'b0;
      mvalid <= 1'b0;
      mcnt   <= 3'd0;
      mprod  <= 16'd0;
    end else if (mbusy) begin
      if (mcnt <= 3'd1) begin
        mbusy  <= 1'b0;
        mvalid <= 1'b1;
      end else begin
        mcnt <= mcnt - 3'd1;
      end
    end else if (mvalid) begin
      if (bus.m_oReady) mvalid <= 1'b0;
    end else if (bus.m_iValid && bus.m_iReady) begin
      mprod <= 16'(bus.m_A) * 16'(bus.m_B);
      mbusy <= 1'b1;
      mcnt  <= 3'd2;
    end
  end

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[8];
  int          checks;
  int          errors;
  logic [15:0] exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, required event not seen", name);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.req_iValid = '0;
    bus.req_oReady = '0;
    bus.req_A = '0;
    bus.req_B = '0;
    mstall = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_done = '0;
  endtask

  task automatic wait_ovalid(input logic [3:0] mask, input string name, output bit ok);
    int n;
    n = 0;
    while ((bus.req_oValid & mask) == 4'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    ok = (n < 60);
    if (!ok) fail_note(name);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    logic [3:0] oh;
    oh = 4'(1 << v.id);
    @(negedge clock);
    bus.req_A[v.id*8 +: 8] = v.a;
    bus.req_B[v.id*8 +: 8] = v.b;
    bus.req_iValid[v.id] = 1'b1;
    bus.req_oReady[v.id] = 1'b1;
    mstall = (v.stall != 0);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    n = 0;
    while (bus.req_iReady !== oh && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 50) begin
      fail_note("grant_timeout");
      bus.req_iValid[v.id] = 1'b0;
      mstall = 1'b0;
      return;
    end
    @(negedge clock);
    bus.req_iValid[v.id] = 1'b0;
    bus.req_A[v.id*8 +: 8] = ~v.a;
    bus.req_B[v.id*8 +: 8] = ~v.b;
    check("owner", {30'd0, owner}, 32'(v.id));
    check("busy", {31'd0, busy}, 32'd1);
    n = 1;
    if (v.stall != 0) begin
      repeat (v.stall) begin
        @(negedge clock);
        n++;
      end
      check("issue_hold_valid", {31'd0, bus.m_iValid}, 32'd1);
      check("issue_hold_a", {24'd0, bus.m_A}, {24'd0, v.a});
      check("issue_hold_b", {24'd0, bus.m_B}, {24'd0, v.b});
      mstall = 1'b0;
    end
    while (bus.req_oValid === 4'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      fail_note("result_timeout");
    end else begin
      if (v.stall == 0) check("latency", 32'(n), 32'd5);
      check("ovalid_onehot", {28'd0, bus.req_oValid}, {28'd0, oh});
      check("result", {16'd0, bus.req_result}, {16'd0, v.exp});
      check("iready_quiet", {28'd0, bus.req_iReady}, 32'd0);
    end
    @(negedge clock);
    exp_done = exp_done + 16'd1;
    check("ovalid_clear", {28'd0, bus.req_oValid}, 32'd0);
    check("done_count", {16'd0, done_count}, {16'd0, exp_done});
    check("owner_idle", {30'd0, owner}, 32'd0);
    bus.req_oReady[v.id] = 1'b0;
  endtask

  initial begin
    int   exp_order[5];
    int   order[5];
    int   ng;
    int   nr;
    int   viol;
    bit   drop;
    bit   ok;

    checks = 0;
    errors = 0;
    exp_done = '0;
    reset = 1'b0;
    mstall = 1'b0;
    bus.req_iValid = 4'b0001;
    bus.req_oReady = '0;
    bus.req_A = '0;
    bus.req_B = '0;

    vecs[0] = '{id: 0, a: 8'd12,  b: 8'd11,  stall: 0, exp: 16'd132};
    vecs[1] = '{id: 1, a: 8'd255, b: 8'd255, stall: 0, exp: 16'd65025};
    vecs[2] = '{id: 2, a: 8'd0,   b: 8'd200, stall: 0, exp: 16'd0};
    vecs[3] = '{id: 3, a: 8'd3,   b: 8'd5,   stall: 2, exp: 16'd15};
    vecs[4] = '{id: 0, a: 8'd200, b: 8'd3,   stall: 1, exp: 16'd600};
    vecs[5] = '{id: 1, a: 8'd1,   b: 8'd1,   stall: 0, exp: 16'd1};
    vecs[6] = '{id: 2, a: 8'd128, b: 8'd2,   stall: 0, exp: 16'd256};
    vecs[7] = '{id: 3, a: 8'd17,  b: 8'd15,  stall: 0, exp: 16'd255};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state, with a requester already asking
    repeat (2) @(negedge clock);
    check("rst_iready", {28'd0, bus.req_iReady}, 32'd0);
    check("rst_ovalid", {28'd0, bus.req_oValid}, 32'd0);
    check("rst_m_ivalid", {31'd0, bus.m_iValid}, 32'd0);
    check("rst_m_oready", {31'd0, bus.m_oReady}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {16'd0, done_count}, 32'd0);
    bus.req_iValid = '0;
    reset = 1'b1;

    // Single-requester transactions from the vector table
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Two requesters valid together after reset: 0 first, then 1
    apply_reset();
    @(negedge clock);
    bus.req_A = {8'd0, 8'd0, 8'd4, 8'd2};
    bus.req_B = {8'd0, 8'd0, 8'd5, 8'd3};
    bus.req_iValid = 4'b0011;
    bus.req_oReady = 4'b0011;
    #1;
    check("pair_first_grant", {28'd0, bus.req_iReady}, 32'h1);
    @(negedge clock);
    bus.req_iValid[0] = 1'b0;
    check("pair_owner0", {30'd0, owner}, 32'd0);
    wait_ovalid(4'b0001, "pair_res0_timeout", ok);
    if (ok) begin
      check("pair_res0", {16'd0, bus.req_result}, 32'd6);
      check("pair_no_overlap", {28'd0, bus.req_iReady}, 32'd0);
    end
    @(negedge clock);
    check("pair_second_grant", {28'd0, bus.req_iReady}, 32'h2);
    @(negedge clock);
    bus.req_iValid[1] = 1'b0;
    wait_ovalid(4'b0010, "pair_res1_timeout", ok);
    if (ok) check("pair_res1", {16'd0, bus.req_result}, 32'd20);
    @(negedge clock);
    check("pair_done", {16'd0, done_count}, 32'd2);
    bus.req_oReady = '0;

    // All four valid continuously: grants rotate 0,1,2,3,0
    apply_reset();
    @(negedge clock);
    bus.req_A = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.req_B = {8'd10, 8'd10, 8'd10, 8'd10};
    bus.req_iValid = 4'hF;
    bus.req_oReady = 4'hF;
    ng = 0;
    nr = 0;
    viol = 0;
    drop = 1'b0;
    for (int k = 0; k < 5; k++) order[k] = -1;
    for (int cyc = 0; cyc < 400 && nr < 5; cyc++) begin
      #1;
      if ($countones(bus.req_iReady) > 1 || $countones(bus.req_oValid) > 1 ||
          (bus.req_iReady != 4'b0 && bus.req_oValid != 4'b0)) viol++;
      if (bus.req_iReady != 4'b0 && ng < 5) begin
        for (int k = 0; k < 4; k++) if (bus.req_iReady[k]) order[ng] = k;
        ng++;
        if (ng == 5) drop = 1'b1;
      end
      if (bus.req_oValid != 4'b0 && nr < 5) begin
        check("rr_ovalid", {28'd0, bus.req_oValid}, 32'(1 << exp_order[nr]));
        check("rr_result", {16'd0, bus.req_result}, 32'((exp_order[nr] + 1) * 10));
        nr++;
      end
      @(negedge clock);
      if (drop) bus.req_iValid = '0;
    end
    if (nr < 5) fail_note("rr_results_timeout");
    for (int k = 0; k < 5; k++) check("rr_order", 32'(order[k]), 32'(exp_order[k]));
    check("rr_protocol", 32'(viol), 32'd0);
    @(negedge clock);
    check("rr_done", {16'd0, done_count}, 32'd5);
    bus.req_oReady = '0;

    // Owner stalls the return for 10 cycles; no new grant meanwhile
    @(negedge clock);
    bus.req_A[2*8 +: 8] = 8'd10;
    bus.req_B[2*8 +: 8] = 8'd10;
    bus.req_iValid = 4'b0100;
    bus.req_oReady = 4'b0001;
    #1;
    check("stall_grant2", {28'd0, bus.req_iReady}, 32'h4);
    @(negedge clock);
    bus.req_iValid = 4'b0001;
    bus.req_A[0 +: 8] = 8'd9;
    bus.req_B[0 +: 8] = 8'd9;
    wait_ovalid(4'b0100, "stall_res_timeout", ok);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("stall_ovalid", {28'd0, bus.req_oValid}, 32'h4);
      check("stall_result", {16'd0, bus.req_result}, 32'd100);
      check("stall_no_grant", {28'd0, bus.req_iReady}, 32'd0);
    end
    bus.req_oReady[2] = 1'b1;
    @(negedge clock);
    check("stall_release", {28'd0, bus.req_oValid}, 32'd0);
    check("stall_next_grant", {28'd0, bus.req_iReady}, 32'h1);
    bus.req_oReady[2] = 1'b0;
    @(negedge clock);
    bus.req_iValid = '0;
    wait_ovalid(4'b0001, "stall_res0_timeout", ok);
    if (ok) check("stall_res0", {16'd0, bus.req_result}, 32'd81);
    @(negedge clock);
    check("stall_done", {16'd0, done_count}, 32'd7);
    bus.req_oReady = '0;

    // Reset while waiting on the multiplier, then a fresh transaction
    @(negedge clock);
    bus.req_A[1*8 +: 8] = 8'd6;
    bus.req_B[1*8 +: 8] = 8'd7;
    bus.req_iValid = 4'b0010;
    bus.req_oReady = 4'b0010;
    @(negedge clock);
    bus.req_iValid = 4'b0001;
    begin
      int n;
      n = 0;
      while (!bus.m_oReady && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) fail_note("wait_state_timeout");
    end
    reset = 1'b0;
    #1;
    check("abort_iready", {28'd0, bus.req_iReady}, 32'd0);
    check("abort_ovalid", {28'd0, bus.req_oValid}, 32'd0);
    check("abort_m_ivalid", {31'd0, bus.m_iValid}, 32'd0);
    check("abort_m_oready", {31'd0, bus.m_oReady}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_owner", {30'd0, owner}, 32'd0);
    check("abort_done", {16'd0, done_count}, 32'd0);
    check("abort_result", {16'd0, bus.req_result}, 32'd0);
    check("abort_m_a", {24'd0, bus.m_A}, 32'd0);
    @(negedge clock);
    bus.req_iValid = '0;
    bus.req_oReady = '0;
    @(negedge clock);
    reset = 1'b1;
    exp_done = '0;
    run_txn('{id: 3, a: 8'd3, b: 8'd5, stall: 0, exp: 16'd15});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
